// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle integer functional unit between one reservation station and the CDB.
// Optional feature macro EXU_OVERLAP_EN: accept a new op on the same edge the held result broadcasts.
module alu_exec_unit #(
    parameter int unsigned LATENCY = 3
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        in_en,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_data1,
    input  logic [31:0] in_data2,
    input  logic [3:0]  in_label,
    output logic        exe_able,
    output logic        cdb_req,
    input  logic        cdb_grant,
    output logic        bc_en,
    output logic [3:0]  bc_label,
    output logic [31:0] bc_data
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_EXEC = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_AND = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    logic [STATE_W-1:0] state_q,  state_d;
    logic [OP_W-1:0]    op_q,     op_d;
    logic [DATA_W-1:0]  a_q,      a_d;
    logic [DATA_W-1:0]  b_q,      b_d;
    logic [TAG_W-1:0]   tag_q,    tag_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               accept;

    // 32-bit wrap-around integer operations, no flags
    function automatic logic [DATA_W-1:0] alu_f(input logic [OP_W-1:0]   op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        case (op)
            OP_ADD:  alu_f = a + b;
            OP_SUB:  alu_f = a - b;
            OP_AND:  alu_f = a & b;
            default: alu_f = a | b;
        endcase
    endfunction

    // Handshake and broadcast outputs, decoded from the held state
    always_comb begin
        cdb_req  = (state_q == ST_DONE);
`ifdef EXU_OVERLAP_EN
        exe_able = (state_q == ST_IDLE) || ((state_q == ST_DONE) && cdb_grant);
`else
        exe_able = (state_q == ST_IDLE);
`endif
        bc_en    = cdb_req & cdb_grant;
        bc_label = cdb_req ? tag_q    : '0;
        bc_data  = cdb_req ? result_q : '0;
        accept   = in_en & exe_able;
    end

    // Next-state logic; an accept always loads a fresh operand set and restarts the countdown
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        tag_d    = tag_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    result_d = alu_f(op_q, a_q, b_q);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (cdb_grant) begin
                    state_d = accept ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            op_d  = in_op;
            a_d   = in_data1;
            b_d   = in_data2;
            tag_d = in_label;
            cnt_d = CNT_LOAD;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule
